// File: rtl/stream_transpose_pkg.sv
// Shared types and defaults for the ping-pong block transposer.
package stream_transpose_pkg;

   localparam int unsigned N_DEFAULT          = 8;
   localparam int unsigned COEF_WIDTH_DEFAULT = 16;
   localparam int unsigned ID_WIDTH           = 4;
   localparam int unsigned DEST_WIDTH         = 4;
   localparam int unsigned USER_WIDTH         = 4;

   typedef logic [COEF_WIDTH_DEFAULT-1:0] coef_t;
   typedef coef_t [N_DEFAULT-1:0]         row_t;
   typedef row_t [N_DEFAULT-1:0]          block_t;

   // Per-bank state captured with the first row of a block.
   typedef struct packed {
      logic                  mode;
      logic [ID_WIDTH-1:0]   id;
      logic [DEST_WIDTH-1:0] dest;
      logic [USER_WIDTH-1:0] user;
   } bank_meta_t;

endpackage

// File: rtl/transpose_bank.sv
// One N x N coefficient array: row write port, read port returning row or column b.
module transpose_bank #(
   parameter int unsigned N          = 8,
   parameter int unsigned COEF_WIDTH = 16,
   localparam int unsigned AW        = $clog2(N),
   localparam int unsigned W         = N * COEF_WIDTH
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_row,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_beat,
   input  logic          rd_col,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [N];

   // Storage is deliberately not reset; the full flags gate every read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_row] <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_col) begin
         for (int r = 0; r < N; r++) begin
            rd_data[r*COEF_WIDTH +: COEF_WIDTH] = mem[r][rd_beat*COEF_WIDTH +: COEF_WIDTH];
         end
      end else begin
         rd_data = mem[rd_beat];
      end
   end

endmodule

// File: rtl/stream_transpose_pp.sv
// Streaming N x N block transposer with two ping-pong banks between row and column passes.
module stream_transpose_pp
   import stream_transpose_pkg::*;
#(
   parameter int unsigned N          = N_DEFAULT,
   parameter int unsigned COEF_WIDTH = COEF_WIDTH_DEFAULT,
   localparam int unsigned W         = N * COEF_WIDTH,
   localparam int unsigned KW        = W / 8,
   localparam int unsigned AW        = $clog2(N)
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  transpose_en,
   output logic                  err_o,
   // row input
   input  logic                  in_t_valid,
   output logic                  in_t_ready,
   input  logic [W-1:0]          in_t_data,
   input  logic                  in_t_last,
   input  logic [KW-1:0]         in_t_keep,
   input  logic [KW-1:0]         in_t_strb,
   input  logic [ID_WIDTH-1:0]   in_t_id,
   input  logic [DEST_WIDTH-1:0] in_t_dest,
   input  logic [USER_WIDTH-1:0] in_t_user,
   // column / row output
   output logic                  out_t_valid,
   input  logic                  out_t_ready,
   output logic [W-1:0]          out_t_data,
   output logic                  out_t_last,
   output logic [KW-1:0]         out_t_keep,
   output logic [KW-1:0]         out_t_strb,
   output logic [ID_WIDTH-1:0]   out_t_id,
   output logic [DEST_WIDTH-1:0] out_t_dest,
   output logic [USER_WIDTH-1:0] out_t_user
);

   logic [1:0]          full_q, full_d;
   logic                wr_sel_q, wr_sel_d;
   logic                rd_sel_q, rd_sel_d;
   logic [AW-1:0]       wr_row_q, wr_row_d;
   logic [AW-1:0]       rd_beat_q, rd_beat_d;
   logic                err_q, err_d;
   bank_meta_t [1:0]    meta_q, meta_d;

   logic                accept, out_hs, wr_last, rd_last;
   logic [W-1:0]        bank_rd [2];

   logic                unused_in;
   assign unused_in = ^{in_t_keep, in_t_strb};

   assign in_t_ready  = !full_q[wr_sel_q];
   assign accept      = in_t_valid && in_t_ready;
   assign out_t_valid = full_q[rd_sel_q];
   assign out_hs      = out_t_valid && out_t_ready;
   assign wr_last     = (wr_row_q == AW'(N - 1));
   assign rd_last     = (rd_beat_q == AW'(N - 1));

   always_comb begin
      full_d    = full_q;
      wr_sel_d  = wr_sel_q;
      rd_sel_d  = rd_sel_q;
      wr_row_d  = wr_row_q;
      rd_beat_d = rd_beat_q;
      err_d     = err_q;
      meta_d    = meta_q;

      if (accept) begin
         if (wr_row_q == '0) begin
            meta_d[wr_sel_q] = '{mode: transpose_en, id: in_t_id, dest: in_t_dest,
                                 user: in_t_user};
         end
         // Framing is by beat count; a misplaced t_last only flags the error.
         if (in_t_last != wr_last) begin
            err_d = 1'b1;
         end
         // N is a power of two, so the increment wraps to 0 after row N-1.
         wr_row_d = wr_row_q + 1'b1;
         if (wr_last) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
         end
      end

      // Write and read of the same bank never coincide: one needs it empty, the other full.
      if (out_hs) begin
         rd_beat_d = rd_beat_q + 1'b1;
         if (rd_last) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         full_q    <= '0;
         wr_sel_q  <= 1'b0;
         rd_sel_q  <= 1'b0;
         wr_row_q  <= '0;
         rd_beat_q <= '0;
         err_q     <= 1'b0;
      end else begin
         full_q    <= full_d;
         wr_sel_q  <= wr_sel_d;
         rd_sel_q  <= rd_sel_d;
         wr_row_q  <= wr_row_d;
         rd_beat_q <= rd_beat_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge aclk) begin
      meta_q <= meta_d;
   end

   for (genvar i = 0; i < 2; i++) begin : g_bank
      transpose_bank #(
         .N          (N),
         .COEF_WIDTH (COEF_WIDTH)
      ) u_bank (
         .clk     (aclk),
         .wr_en   (accept && (wr_sel_q == 1'(i))),
         .wr_row  (wr_row_q),
         .wr_data (in_t_data),
         .rd_beat (rd_beat_q),
         .rd_col  (meta_q[i].mode),
         .rd_data (bank_rd[i])
      );
   end

   assign out_t_data = bank_rd[rd_sel_q];
   assign out_t_last = rd_last;
   assign out_t_keep = '1;
   assign out_t_strb = '1;
   assign out_t_id   = meta_q[rd_sel_q].id;
   assign out_t_dest = meta_q[rd_sel_q].dest;
   assign out_t_user = meta_q[rd_sel_q].user;
   assign err_o      = err_q;

endmodule

// File: doc/stream_transpose_pp.md
Name: stream_transpose_pp

Overview:
- Streaming N×N block transposer with ping-pong buffering.
- Input: one row of N coefficients per beat on a nasti_stream_channel. Output: one column per beat, or one row per beat in bypass mode.
- Sits between the row-pass and column-pass of the 2-D (I)DCT datapath. Sustains full throughput once both banks are in flight.

Parameters:
- N, 8, block dimension (rows = columns = beats per block); N ≥ 2, power of 2.
- COEF_WIDTH, 16, bits per coefficient; beat data width = N*COEF_WIDTH.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- areset  input  1  synchronous, active-high reset.
- transpose_en  input  1  mode; sampled with the first accepted row of each block (1 = transpose, 0 = bypass).
- err_o  output  1  sticky framing error flag; cleared only by areset.
- in_ch  nasti_stream_channel.slave  N*COEF_WIDTH data  row input; coefficient k at bits [k*COEF_WIDTH +: COEF_WIDTH].
- out_ch  nasti_stream_channel.master  N*COEF_WIDTH data  column/row output.

Behaviour:
- Storage: two banks, each N×N×COEF_WIDTH. Per-bank state: full flag, captured mode, captured t_id/t_dest/t_user.
- Write pointer: wr_sel (1 bit), wr_row (log2 N bits).
- in_ch.t_ready = !full[wr_sel]. Accept = t_valid && t_ready.
- On accept:
  - Store the row at bank[wr_sel][wr_row].
  - If wr_row == 0, capture transpose_en, t_id, t_dest, t_user into the bank.
  - If wr_row == N-1: set full[wr_sel], toggle wr_sel, wr_row wraps to 0. Otherwise wr_row increments.
- Read pointer: rd_sel, rd_beat. out_ch.t_valid = full[rd_sel].
- Output data on beat b:
  - Transpose: element r = bank[rd_sel][r][b], for r = 0..N-1.
  - Bypass: element r = bank[rd_sel][b][r].
- Output sideband:
  - t_last = (rd_beat == N-1).
  - t_keep and t_strb all ones.
  - t_id/t_dest/t_user = the bank's captured values.
- On out handshake: if rd_beat == N-1, clear full[rd_sel], toggle rd_sel, rd_beat wraps to 0. Otherwise rd_beat increments.
- Latency: first output beat has t_valid high in the cycle after the handshake of input row N-1 (1 cycle).
- Throughput: N beats in, N beats out per block. No bubbles when both sides stay ready.
- Simultaneous events:
  - Write completing one bank and read completing the other bank in the same cycle: both flags update independently.
  - Write to bank X and read of bank X never coincide; this is guaranteed by the full flags.
- Both banks full: in_ch.t_ready = 0 until the read side frees a bank.
- Output stall: data and sideband held stable while t_valid && !t_ready (AXI-stream rule).
- Framing:
  - Blocks are framed by beat count only.
  - in t_last on a row other than N-1 sets err_o. So does t_last low on row N-1.
  - The block still closes at N rows.
- Input t_keep/t_strb are ignored.
- Reset:
  - full = 0, wr_sel = rd_sel = 0, wr_row = rd_beat = 0, err_o = 0.
  - out_ch.t_valid = 0, in_ch.t_ready = 1 in the cycle after reset.
  - Reset mid-block discards all buffered data; the partial block is dropped.
  - Bank contents are not reset; only the control state is.

Decomposition:
- Package stream_transpose_pkg:
  - coef_t (logic [COEF_WIDTH-1:0]).
  - row_t (coef_t [N-1:0]).
  - block_t (row_t [N-1:0]).
  - bank_meta_t struct (mode, id, dest, user).
  - Default N/COEF_WIDTH constants.
- Sub-module transpose_bank: one N×N register array. Row write port; read port selectable as row b or column b by a mode input. Instantiated twice.
- Top level holds the pointer/flag control and the output mux.

Test Plan:
- Reset, then one block with in[r][c] = r*N+c, transpose_en=1, out always ready -> out beats b = 0..7 carry element r = r*8+b; t_last only on beat 7; first out t_valid 1 cycle after row 7 is accepted.
- Same data with transpose_en=0 -> out beat b equals input row b exactly.
- 4 back-to-back blocks with modes alternating 1,0,1,0, both sides always valid/ready -> 32 in and 32 out handshakes with no idle cycles after the first block; each block uses its own mode.
- out_ch.t_ready = 0 for 20 cycles while input streams -> in t_ready drops after 16 rows accepted; output data stays stable during the stall; no data loss when released.
- Input t_last on row 3 -> err_o = 1 and stays set; the block still outputs 8 beats; err_o clears only after areset.
- areset asserted after 5 rows of a block, then a fresh full block -> only the fresh block appears on out_ch; t_id/t_user on the output match the fresh block's first row.
